// File: rtl/draw_rect_pkg.sv
// Shared types and default parameters for the rectangle position controller.
// The state encoding is visible on the debug port, so its values are fixed here.
package draw_rect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FALL   = 2'd1,
    ST_BOTTOM = 2'd2
  } state_e;

  localparam int DEF_SCREEN_HEIGHT = 600;
  localparam int DEF_RECT_HEIGHT   = 64;
  localparam int DEF_TICK_CYCLES   = 400000;
  localparam int DEF_ACCEL         = 1;
  localparam int DEF_VMAX          = 32;

  localparam int POS_W = 12;
  localparam int VEL_W = 6;

  // The sum carries one extra bit, so a large position plus velocity clamps instead of wrapping.
  function automatic logic [POS_W-1:0] clamp_floor(input logic [POS_W:0]   v,
                                                   input logic [POS_W-1:0] floor_v);
    return (v > {1'b0, floor_v}) ? floor_v : v[POS_W-1:0];
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a rising-edge
// detector that produces a single-cycle pulse in the pclk domain.
module sync_edge (
  input  logic pclk,
  input  logic rst,
  input  logic d_async,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // NOTE: non-blocking assignments make the three flops shift as one chain;
  // blocking ones would collapse the chain into a single stage.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d_async;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/draw_rect_ctl.sv
// Position controller for the image: follows the mouse, drops under constant
// acceleration to the screen floor on a click, and returns on a further click.
module draw_rect_ctl
  import draw_rect_pkg::*;
#(
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int RECT_HEIGHT   = DEF_RECT_HEIGHT,
  parameter int TICK_CYCLES   = DEF_TICK_CYCLES,
  parameter int ACCEL         = DEF_ACCEL,
  parameter int VMAX          = DEF_VMAX
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [POS_W-1:0] mouse_xpos,
  input  logic [POS_W-1:0] mouse_ypos,
  input  logic             mouse_left,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic             falling,
  output logic [1:0]       state
);

  localparam logic [POS_W-1:0]  FLOOR     = POS_W'(SCREEN_HEIGHT - RECT_HEIGHT);
  localparam int                TICK_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [VEL_W:0]    ACCEL_V   = (VEL_W + 1)'(ACCEL);
  localparam logic [VEL_W:0]    VMAX_V    = (VEL_W + 1)'(VMAX);

  state_e             state_q, state_d;
  logic [POS_W-1:0]   xpos_q, xpos_d;
  logic [POS_W-1:0]   ypos_q, ypos_d;
  logic [VEL_W-1:0]   vel_q, vel_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic               falling_q;

  logic               click;
  logic               tick_wrap;
  logic [VEL_W:0]     vel_sum;
  logic [VEL_W-1:0]   vel_n;
  logic [POS_W:0]     y_sum;
  logic [POS_W-1:0]   y_next;

  sync_edge u_sync_edge (
    .pclk    (pclk),
    .rst     (rst),
    .d_async (mouse_left),
    .rise    (click)
  );

  // Physics step evaluated every cycle; only committed on the tick wrap.
  always_comb begin
    tick_wrap = (tick_q == TICK_LAST);
    vel_sum   = {1'b0, vel_q} + ACCEL_V;
    vel_n     = (vel_sum > VMAX_V) ? VMAX_V[VEL_W-1:0] : vel_sum[VEL_W-1:0];
    y_sum     = {1'b0, ypos_q} + {{(POS_W + 1 - VEL_W){1'b0}}, vel_n};
    y_next    = clamp_floor(y_sum, FLOOR);
  end

  // NOTE: every next-state signal takes its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    vel_d   = vel_q;
    tick_d  = tick_q;

    case (state_q)
      ST_IDLE: begin
        xpos_d = mouse_xpos;
        ypos_d = mouse_ypos;
        if (click) begin
          state_d = ST_FALL;
          ypos_d  = clamp_floor({1'b0, mouse_ypos}, FLOOR);
          vel_d   = '0;
          tick_d  = '0;
        end
      end

      ST_FALL: begin
        if (tick_wrap) begin
          tick_d = '0;
          vel_d  = vel_n;
          ypos_d = y_next;
          if (y_next == FLOOR) begin
            state_d = ST_BOTTOM;
            vel_d   = '0;
          end
        end else begin
          tick_d = tick_q + TICK_ONE;
        end
      end

      ST_BOTTOM: begin
        tick_d = '0;
        if (click) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        vel_d   = '0;
        tick_d  = '0;
      end
    endcase
  end

  // falling is derived from the next state so it changes on the same edge as state.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      xpos_q    <= '0;
      ypos_q    <= '0;
      vel_q     <= '0;
      tick_q    <= '0;
      falling_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
      vel_q     <= vel_d;
      tick_q    <= tick_d;
      falling_q <= (state_d == ST_FALL);
    end
  end

  assign xpos    = xpos_q;
  assign ypos    = ypos_q;
  assign falling = falling_q;
  assign state   = state_q;

endmodule
